monitor_rango_temp: RTL

- Multi-channel temperature range supervisor for the monitoring datapath. Sits after the per-sensor temperature registers.
- Classifies each channel's scaled signed temperature (0.1 °C units) as NORMAL, FRIO or ALTO.
- Applies consecutive-sample confirmation and hysteresis to reject noise and chatter.
- Raises sticky per-channel alarms that stay set until software acknowledges them.

---
 rtl/monitor_rango_temp.sv | 126 ++++++++++++
 1 files changed

// File: rtl/monitor_rango_temp.sv
// Multi-channel temperature range supervisor. Each channel is classified as NORMAL/FRIO/ALTO
// with consecutive-sample confirmation, exit hysteresis and a sticky, software-acknowledged alarm.
module monitor_rango_temp #(
  parameter int ANCHO          = 11,
  parameter int NUM_CANALES    = 4,
  parameter int TEMP_FRIO      = 180,
  parameter int TEMP_ALTO      = 250,
  parameter int HISTERESIS     = 5,
  parameter int CONFIRMACIONES = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         temp_valida,
  input  logic [NUM_CANALES*ANCHO-1:0] temp_canal,
  input  logic [NUM_CANALES-1:0]       ack_alarma,
  output logic [2*NUM_CANALES-1:0]     estado,
  output logic [NUM_CANALES-1:0]       fuera_rango,
  output logic [NUM_CANALES-1:0]       alarma_canal,
  output logic                         alarma
);

  localparam int CW = $clog2(CONFIRMACIONES + 1);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    FRIO   = 2'b01,
    ALTO   = 2'b10
  } estado_t;

  // One extra bit keeps TEMP_FRIO+HISTERESIS / TEMP_ALTO-HISTERESIS representable.
  localparam logic signed [ANCHO:0] LIM_FRIO = (ANCHO+1)'(TEMP_FRIO);
  localparam logic signed [ANCHO:0] LIM_ALTO = (ANCHO+1)'(TEMP_ALTO);
  localparam logic signed [ANCHO:0] SAL_FRIO = (ANCHO+1)'(TEMP_FRIO + HISTERESIS);
  localparam logic signed [ANCHO:0] SAL_ALTO = (ANCHO+1)'(TEMP_ALTO - HISTERESIS);
  localparam logic [CW:0]           CONF_W   = (CW+1)'(CONFIRMACIONES);

  if ((TEMP_FRIO + HISTERESIS > TEMP_ALTO - HISTERESIS) || (CONFIRMACIONES < 1)) begin : g_param_err
    $error("monitor_rango_temp: inconsistent thresholds or CONFIRMACIONES < 1");
  end

  for (genvar g = 0; g < NUM_CANALES; g++) begin : g_canal
    estado_t               st_q, st_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  dir_q, dir_d;   // pending direction in NORMAL: 0 cold, 1 hot
    logic                  alarma_q;
    logic                  entra;
    logic [CW:0]           cuenta;
    logic signed [ANCHO:0] muestra;

    assign muestra = {temp_canal[g*ANCHO + ANCHO - 1], temp_canal[g*ANCHO +: ANCHO]};

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      cuenta = '0;
      if (temp_valida) begin
        unique case (st_q)
          NORMAL: begin
            if ((muestra < LIM_FRIO) || (muestra > LIM_ALTO)) begin
              dir_d  = (muestra > LIM_ALTO);
              // A direction change restarts the run with this sample as its first.
              cuenta = ((cnt_q != '0) && (dir_q != dir_d)) ? (CW+1)'(1)
                                                           : {1'b0, cnt_q} + (CW+1)'(1);
              if (cuenta >= CONF_W) begin
                st_d  = dir_d ? ALTO : FRIO;
                cnt_d = '0;
              end else begin
                cnt_d = cuenta[CW-1:0];
              end
            end else begin
              cnt_d = '0;
            end
          end
          FRIO, ALTO: begin
            if (((st_q == FRIO) && (muestra >= SAL_FRIO)) ||
                ((st_q == ALTO) && (muestra <= SAL_ALTO))) begin
              cuenta = {1'b0, cnt_q} + (CW+1)'(1);
              if (cuenta >= CONF_W) begin
                st_d  = NORMAL;
                cnt_d = '0;
              end else begin
                cnt_d = cuenta[CW-1:0];
              end
            end else begin
              cnt_d = '0;
            end
          end
          default: begin
            st_d  = NORMAL;
            cnt_d = '0;
          end
        endcase
      end
    end

    assign entra = temp_valida && (st_q == NORMAL) && (st_d != NORMAL);

    // NOTE: state registers use non-blocking assignments so every channel samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q     <= NORMAL;
        cnt_q    <= '0;
        dir_q    <= 1'b0;
        alarma_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        dir_q <= dir_d;
        if (entra) begin
          alarma_q <= 1'b1;
        end else if (ack_alarma[g]) begin
          alarma_q <= 1'b0;
        end
      end
    end

    assign estado[2*g +: 2] = st_q;
    assign fuera_rango[g]   = (st_q != NORMAL);
    assign alarma_canal[g]  = alarma_q;
  end

  assign alarma = |alarma_canal;

endmodule
